// File: rtl/hswap_check.sv
// Scoreboard checker: queues halfword-swapped stimulus words and compares them with returned results.
// Optional macro HSWAP_CHECK_ZERO_SKIP_EN: a zero result is counted but never treated as a mismatch.
module hswap_check #(
   parameter int DEPTH      = 4,
   parameter int SWAPS      = 3,
   parameter int NUM_CHECKS = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_a,
   input  logic        res_valid,
   input  logic [31:0] res_data,
   output logic        err,
   output logic        underflow,
   output logic [7:0]  mismatch_cnt,
   output logic [7:0]  check_cnt,
   output logic        done
);

   localparam int             AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int             CW      = AW + 1;
   localparam logic [CW-1:0]  LP_FULL = CW'(DEPTH);
   localparam logic [7:0]     LP_NC   = 8'(NUM_CHECKS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   function automatic logic [31:0] hswap_n(input logic [31:0] a);
      logic [31:0] v;
      v = a;
      for (int i = 0; i < SWAPS; i++) begin
         v = {v[15:0], v[31:16]};
      end
      return v;
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] c);
      return (c == 8'hFF) ? c : c + 8'd1;
   endfunction

   state_t         r_state;
   state_t         w_state_nxt;
   logic [31:0]    r_mem [DEPTH];
   logic [AW-1:0]  r_wr_ptr;
   logic [AW-1:0]  r_rd_ptr;
   logic [CW-1:0]  r_count;
   logic           r_err;
   logic           r_underflow;
   logic [7:0]     r_mm_cnt;
   logic [7:0]     r_chk_cnt;

   logic           w_run;
   logic           w_full;
   logic           w_empty;
   logic           w_push;
   logic           w_pop;
   logic           w_uflow;
   logic           w_diff;
   logic [31:0]    w_head;
   logic [7:0]     w_chk_nxt;

   assign w_run     = (r_state == S_RUN);
   assign w_full    = (r_count == LP_FULL);
   assign w_empty   = (r_count == '0);
   assign in_ready  = w_run && !w_full;
   assign w_push    = in_valid && in_ready;
   assign w_pop     = res_valid && !w_empty && w_run;
   assign w_uflow   = res_valid && w_empty && w_run;
   assign w_head    = r_mem[r_rd_ptr];
   assign w_chk_nxt = sat_inc(r_chk_cnt);

`ifdef HSWAP_CHECK_ZERO_SKIP_EN
   assign w_diff = (res_data != w_head) && (res_data != 32'd0);
`else
   assign w_diff = (res_data != w_head);
`endif

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  w_state_nxt = S_RUN;
         S_RUN:   if (w_pop && (w_chk_nxt == LP_NC)) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_DONE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_err       <= 1'b0;
         r_underflow <= 1'b0;
         r_mm_cnt    <= 8'd0;
         r_chk_cnt   <= 8'd0;
      end else begin
         r_state <= w_state_nxt;
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         if (w_pop) begin
            r_chk_cnt <= w_chk_nxt;
            if (w_diff) begin
               r_mm_cnt <= sat_inc(r_mm_cnt);
               r_err    <= 1'b1;
            end
         end
         if (w_uflow) begin
            r_underflow <= 1'b1;
            r_err       <= 1'b1;
         end
      end
   end

   // FIFO storage carries data only, so it is left out of reset
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= hswap_n(in_a);
   end

   assign err          = r_err;
   assign underflow    = r_underflow;
   assign mismatch_cnt = r_mm_cnt;
   assign check_cnt    = r_chk_cnt;
   assign done         = (r_state == S_DONE);

endmodule
